// File: rtl/sine_pkg.sv
// Shared widths, table builder and midscale constant for the DDS sine source.
// Imported by the quarter-wave ROM and the generator top level.
package sine_pkg;

    localparam int PHASE_W_D = 16;
    localparam int ADDR_W_D  = 6;
    localparam int DATA_W_D  = 12;
    localparam int AMP_W_D   = 8;

    localparam real PI = 3.14159265358979323846;

    // Half-step offset keeps mirrored quarters symmetric
    function automatic int quarter_sine(input int k, input int addr_w,
                                        input int data_w);
        real full;
        real ang;
        full = real'((1 << (data_w - 1)) - 1);
        ang  = PI * real'(2 * k + 1) / real'(1 << (addr_w + 2));
        return $rtoi(full * $sin(ang) + 0.5);
    endfunction

    function automatic int MIDSCALE(input int data_w);
        return 1 << (data_w - 1);
    endfunction

endpackage

// File: rtl/dds_sine_gen_if.sv
// Control inputs and sample outputs of the DDS sine generator.
// master drives the controls, slave is the generator.
interface dds_sine_gen_if #(
    parameter int PHASE_W = 16,
    parameter int DATA_W  = 12,
    parameter int AMP_W   = 8
);
    logic               en;
    logic               sync_clr;
    logic [PHASE_W-1:0] ftw;
    logic [PHASE_W-1:0] phase_off;
    logic [AMP_W-1:0]   amp;
    logic [DATA_W-1:0]  d_out;
    logic               d_valid;
    logic               wrap;

    modport master (
        output en, sync_clr, ftw, phase_off, amp,
        input  d_out, d_valid, wrap
    );

    modport slave (
        input  en, sync_clr, ftw, phase_off, amp,
        output d_out, d_valid, wrap
    );
endinterface

// File: rtl/quarter_sine_rom.sv
// Quarter-wave sine table, built at elaboration time.
// Registered read with enable, one cycle of latency.
module quarter_sine_rom
    import sine_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_D,
    parameter int DATA_W = DATA_W_D
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] addr,
    output logic [DATA_W-2:0] q
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-2:0] tbl [DEPTH];

    for (genvar g = 0; g < DEPTH; g++) begin : g_tbl
        localparam int V = quarter_sine(g, ADDR_W, DATA_W);
        assign tbl[g] = V[DATA_W-2:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (rd_en) begin
            q <= tbl[addr];
        end
    end

endmodule

// File: rtl/dds_sine_gen.sv
// DDS sine source: phase accumulator, quarter-wave lookup, amplitude scaler.
// Three pipeline stages from sample strobe to offset-binary output.
module dds_sine_gen
    import sine_pkg::*;
#(
    parameter int PHASE_W = PHASE_W_D,
    parameter int ADDR_W  = ADDR_W_D,
    parameter int DATA_W  = DATA_W_D,
    parameter int AMP_W   = AMP_W_D
) (
    input logic           clk,
    input logic           rst_n,
    dds_sine_gen_if.slave bus
);

    localparam int PQ_W = ADDR_W + 2;
    localparam logic [DATA_W-1:0] MID = DATA_W'(MIDSCALE(DATA_W));

    logic [PHASE_W-1:0] acc;
    logic [PHASE_W-1:0] acc_next;
    logic [PHASE_W-1:0] p;
    logic               carry;
    logic [PQ_W-1:0]    ptop;

    logic               s1_vld;
    logic               s1_wrap;
    logic               s1_neg;
    logic               s1_mir;
    logic [ADDR_W-1:0]  s1_idx;
    logic [AMP_W-1:0]   s1_amp;

    logic               s2_vld;
    logic               s2_wrap;
    logic               s2_neg;
    logic [AMP_W-1:0]   s2_amp;
    logic [ADDR_W-1:0]  rom_addr;
    logic [DATA_W-2:0]  rom_q;

    logic signed [DATA_W-1:0]      mag;
    logic signed [DATA_W+AMP_W:0]  prod;
    logic signed [DATA_W-1:0]      scaled;

    logic [DATA_W-1:0]  d_out;
    logic               d_valid;
    logic               wrap;

    // A clear forces phase zero and suppresses the overflow flag
    always_comb begin
        {carry, acc_next} = {1'b0, acc} + {1'b0, bus.ftw};
        if (bus.sync_clr) begin
            acc_next = '0;
            carry    = 1'b0;
        end
        p = acc_next + bus.phase_off;
    end

    assign ptop = PQ_W'(p >> (PHASE_W - PQ_W));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc     <= '0;
            s1_vld  <= 1'b0;
            s1_wrap <= 1'b0;
            s1_neg  <= 1'b0;
            s1_mir  <= 1'b0;
            s1_idx  <= '0;
            s1_amp  <= '0;
        end else begin
            s1_vld <= bus.en;
            if (bus.en || bus.sync_clr) begin
                acc <= acc_next;
            end
            if (bus.en) begin
                {s1_neg, s1_mir, s1_idx} <= ptop;
                s1_amp  <= bus.amp;
                s1_wrap <= carry;
            end
        end
    end

    assign rom_addr = s1_mir ? ~s1_idx : s1_idx;

    quarter_sine_rom #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_rom (
        .clk   (clk),
        .rst_n (rst_n),
        .rd_en (s1_vld),
        .addr  (rom_addr),
        .q     (rom_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_vld  <= 1'b0;
            s2_wrap <= 1'b0;
            s2_neg  <= 1'b0;
            s2_amp  <= '0;
        end else begin
            s2_vld <= s1_vld;
            if (s1_vld) begin
                s2_wrap <= s1_wrap;
                s2_neg  <= s1_neg;
                s2_amp  <= s1_amp;
            end
        end
    end

    // Arithmetic shift floors toward minus infinity
    always_comb begin
        mag    = s2_neg ? -$signed({1'b0, rom_q}) : $signed({1'b0, rom_q});
        prod   = mag * $signed({1'b0, s2_amp});
        scaled = DATA_W'(prod >>> AMP_W);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_out   <= MID;
            d_valid <= 1'b0;
            wrap    <= 1'b0;
        end else begin
            d_valid <= s2_vld;
            wrap    <= s2_vld & s2_wrap;
            if (s2_vld) begin
                d_out <= MID + scaled;
            end
        end
    end

    assign bus.d_out   = d_out;
    assign bus.d_valid = d_valid;
    assign bus.wrap    = wrap;

endmodule

// File: tb/tb_dds_sine_gen.sv
// Randomised scoreboard bench for dds_sine_gen at two width sets.
// Expected samples come from a real-valued sine model of the phase.
module tb_dds_sine_gen;

    localparam real PI = 3.14159265358979323846;

    typedef struct {
        int d;
        int wr;
        int cyc;
        int ideal;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   nchk = 0;
    int   nerr = 0;

    exp_t qa[$];
    exp_t qb[$];
    exp_t ea;
    exp_t eb;
    int   cap_a[$];
    int   wrap_idx[$];
    int   vcnt_a = 0;
    int   last_a = 0;
    int   macc = 0;

    dds_sine_gen_if #(.PHASE_W(16), .DATA_W(12), .AMP_W(8)) ia ();
    dds_sine_gen_if #(.PHASE_W(16), .DATA_W(8),  .AMP_W(8)) ib ();

    assign ib.en        = ia.en;
    assign ib.sync_clr  = ia.sync_clr;
    assign ib.ftw       = ia.ftw;
    assign ib.phase_off = ia.phase_off;
    assign ib.amp       = ia.amp;

    dds_sine_gen #(
        .PHASE_W (16), .ADDR_W (6), .DATA_W (12), .AMP_W (8)
    ) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ia)
    );

    dds_sine_gen #(
        .PHASE_W (16), .ADDR_W (4), .DATA_W (8), .AMP_W (8)
    ) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ib)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input int got, input int expv);
        nchk++;
        if (got !== expv) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                     tag, got, expv, cyc);
        end
    endtask

    // Signed sine at the centre of the quantised phase step
    function automatic real mval(input int p, input int aw);
        real pos;
        pos = real'(p >> (14 - aw)) + 0.5;
        return $sin(2.0 * PI * pos / real'(1 << (aw + 2)));
    endfunction

    function automatic int model_d(input int p, input int aw, input int dw,
                                   input int a);
        real v;
        int  m;
        int  q;
        int  s;
        v = mval(p, aw);
        m = (1 << (dw - 1)) - 1;
        q = $rtoi(real'(m) * (v < 0.0 ? -v : v) + 0.5);
        s = (v < 0.0) ? -q : q;
        return (1 << (dw - 1)) + ((s * a) >>> 8);
    endfunction

    function automatic int model_ideal(input int p, input int aw,
                                       input int dw, input int a);
        real r;
        r = real'(1 << (dw - 1))
            + real'(a) / 256.0 * real'((1 << (dw - 1)) - 1) * mval(p, aw);
        return $rtoi(r + 0.5);
    endfunction

    task automatic drive(input bit e, input bit clr, input int f,
                         input int off, input int a);
        int   s;
        int   wr;
        int   p;
        exp_t x;
        ia.en        = e;
        ia.sync_clr  = clr;
        ia.ftw       = 16'(f);
        ia.phase_off = 16'(off);
        ia.amp       = 8'(a);
        if (clr) macc = 0;
        if (e) begin
            if (clr) begin
                wr = 0;
            end else begin
                s    = macc + f;
                wr   = (s >= 65536) ? 1 : 0;
                macc = s % 65536;
            end
            p = (macc + off) % 65536;
            x.cyc   = cyc + 3;
            x.wr    = wr;
            x.d     = model_d(p, 6, 12, a);
            x.ideal = 0;
            qa.push_back(x);
            x.d     = model_d(p, 4, 8, a);
            x.ideal = model_ideal(p, 4, 8, a);
            qb.push_back(x);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        ia.en = 1'b0;
        ia.sync_clr = 1'b0;
        qa.delete();
        qb.delete();
        macc = 0;
    endtask

    always @(negedge clk) begin
        if (ia.d_valid) begin
            vcnt_a++;
            if (qa.size() == 0) begin
                chk("spurious_a", ia.d_valid, 0);
            end else begin
                ea = qa.pop_front();
                chk("dout_a", int'(ia.d_out), ea.d);
                chk("wrap_a", int'(ia.wrap), ea.wr);
                chk("latency_a", cyc, ea.cyc);
                cap_a.push_back(int'(ia.d_out));
                if (ia.wrap) wrap_idx.push_back(cap_a.size() - 1);
                last_a = int'(ia.d_out);
            end
        end else begin
            chk("wrap_novalid_a", int'(ia.wrap), 0);
        end
    end

    always @(negedge clk) begin
        int df;
        if (ib.d_valid) begin
            if (qb.size() == 0) begin
                chk("spurious_b", ib.d_valid, 0);
            end else begin
                eb = qb.pop_front();
                df = int'(ib.d_out) - eb.ideal;
                chk("dout_b", int'(ib.d_out), eb.d);
                chk("wrap_b", int'(ib.wrap), eb.wr);
                chk("ideal_err_b", int'(df >= -1 && df <= 1), 1);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int mx;
        int sum;
        int m;
        ia.en = 0;
        ia.sync_clr = 0;
        ia.ftw = '0;
        ia.phase_off = '0;
        ia.amp = '0;

        // Reset held while strobing
        for (int i = 0; i < 6; i++) begin
            ia.en = i[0];
            @(negedge clk);
            chk("rst_dout", int'(ia.d_out), 2048);
            chk("rst_valid", int'(ia.d_valid), 0);
            chk("rst_wrap", int'(ia.wrap), 0);
            chk("rst_dout_b", int'(ib.d_out), 128);
            @(posedge clk);
            #1;
        end
        ia.en = 0;
        rst_n = 1'b1;
        idle(2);

        // Full-period sweep
        cap_a.delete();
        wrap_idx.delete();
        for (int i = 0; i < 512; i++) drive(1, 0, 16'h0100, 0, 255);
        idle(6);
        chk("sweep_count", cap_a.size(), 512);
        chk("wrap_count", wrap_idx.size(), 2);
        if (wrap_idx.size() == 2) begin
            chk("wrap_pos0", wrap_idx[0], 255);
            chk("wrap_pos1", wrap_idx[1], 511);
        end
        mx = 0;
        for (int j = 0; j < cap_a.size(); j++)
            if (cap_a[j] > mx) mx = cap_a[j];
        chk("peak", mx, 2048 + ((2047 * 255) >> 8));
        if (cap_a.size() >= 256) begin
            for (int j = 0; j < 128; j++) begin
                sum = cap_a[j] + cap_a[j + 128];
                chk("odd_sym", int'(sum == 4095 || sum == 4096), 1);
            end
        end

        // Zero amplitude, random tuning
        for (int i = 0; i < 40; i++)
            drive($urandom_range(0, 1), 0, $urandom_range(0, 65535),
                  $urandom_range(0, 65535), 0);
        idle(5);
        chk("zero_amp_last", last_a, 2048);

        // Phase offset with clear alongside a strobe
        for (int i = 0; i < 5; i++) drive(1, 0, 16'h0400, 16'h4000, 255);
        drive(1, 1, 16'h0400, 16'h4000, 255);
        idle(5);
        chk("clr_peak", last_a, 4087);
        chk("clr_acc_model", macc, 0);

        // Reset with samples in flight
        drive(1, 0, 16'h0100, 0, 255);
        drive(1, 0, 16'h0100, 0, 255);
        vcnt_a = 0;
        do_reset();
        idle(4);
        chk("rst_discard", vcnt_a, 0);
        rst_n = 1'b1;
        idle(1);
        drive(1, 0, 16'h0100, 0, 255);
        idle(5);
        chk("post_rst_count", vcnt_a, 1);
        m = $rtoi(2047.0 * $sin(PI * 3.0 / 256.0) + 0.5);
        chk("post_rst_first", last_a, 2048 + ((m * 255) >> 8));

        // Random mix of strobes, clears and settings
        for (int i = 0; i < 400; i++)
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0,
                  $urandom_range(0, 65535), $urandom_range(0, 65535),
                  $urandom_range(0, 255));
        idle(6);
        chk("queue_a_empty", qa.size(), 0);
        chk("queue_b_empty", qb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule

// File: doc/dds_sine_gen.md
# dds_sine_gen

Parametrised direct-digital-synthesis sine source that replaces the fixed 6-bit address counter plus full-period ROM feeding the DAC model. A phase accumulator advances by a programmable tuning word on each sample strobe and addresses a quarter-wave table through a sub-module. The result is amplitude-scaled and emitted as offset-binary samples with a valid strobe, ready for the DAC `I_data`/`en` inputs. Runs on the 100 MHz system clock; the sample rate is set by an external TickCounter strobe.

## Interface
- `PHASE_W`, 16: phase accumulator width; tuning word and phase offset width.
- `ADDR_W`, 6: quarter-wave table address width. The table has 2^ADDR_W entries; the full period spans 2^(ADDR_W+2) points.
- `DATA_W`, 12: output sample width. Must be ≥ 4.
- `AMP_W`, 8: amplitude control width.
- `clk` in 1: system clock, rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `en` in 1: sample strobe, one cycle wide; advances the accumulator and launches one sample.
- `ftw` in PHASE_W: frequency tuning word, sampled on `en`.
- `phase_off` in PHASE_W: phase offset added at lookup, sampled on `en`.
- `amp` in AMP_W: amplitude, unsigned; gain = amp/2^AMP_W. Sampled on `en`.
- `sync_clr` in 1: synchronous accumulator clear.
- `d_out` out DATA_W: offset-binary sample; midscale = 2^(DATA_W-1).
- `d_valid` out 1: one-cycle strobe marking a new `d_out`.
- `wrap` out 1: one-cycle strobe, coincident with `d_valid`, flagging the first sample after accumulator overflow.

## Operation
- **Accumulator `acc`:**
  - On `en`: `acc <= acc + ftw`, mod 2^PHASE_W.
  - On overflow (carry out), the overflow flag travels down the pipeline with that sample.
- **`sync_clr`:**
  - Sets `acc <= 0` and wins over `en` in the same cycle.
  - If both are high, the sample launched uses phase 0 plus `phase_off`, with no wrap flag.
  - In-flight pipeline samples still complete.
- **Lookup phase:** `p = acc_next + phase_off`, where `acc_next` is the updated value. Use the top ADDR_W+2 bits of `p`:
  - bit[top] = `neg` (second half-period).
  - bit[top-1] = `mir` (mirror the quarter).
  - the low ADDR_W bits are the index `i`.
  - Table address = `mir ? ~i : i`.
- **Table entry k** = round((2^(DATA_W-1)-1) · sin(π(2k+1)/2^(ADDR_W+2))). Entries are unsigned DATA_W-1 bits. The half-step offset makes the mirrored quarters exactly symmetric, so no zero-crossing entry is needed.
- **Scale:** `s = neg ? -q : q`, signed DATA_W bits. `prod = s * amp` (signed × unsigned, DATA_W+AMP_W+1 bits). `scaled = prod >>> AMP_W`, arithmetic shift, truncation toward −∞.
- **Output:** `d_out = 2^(DATA_W-1) + scaled`. This cannot overflow, because amp < 2^AMP_W.
- **Back-to-back `en`:** permitted; the pipeline is fully pipelined with one sample per cycle.
- `ftw`, `phase_off` and `amp` may change at any time. Only values present on an `en` cycle take effect.

## Timing
- Three-stage pipeline. `en` in cycle n gives `d_valid` and `d_out` in cycle n+3:
  - Stage 1 registers `acc`, `p`, `amp`, and the wrap flag.
  - Stage 2 performs the ROM read (registered) and carries `neg`.
  - Stage 3 performs the multiply, offset, and output register.
- `d_out` holds its value between strobes.
- `wrap` is asserted only together with `d_valid`.
- **Reset values:**
  - `acc` = 0.
  - all pipeline valids = 0.
  - `d_valid` = 0, `wrap` = 0.
  - `d_out` = 2^(DATA_W-1) (midscale).
- Reset mid-operation discards all in-flight samples; no `d_valid` is produced for them after release.
- The first `en` after reset with `ftw` = F gives a lookup phase of F + `phase_off`. The initial phase-0 point is never emitted unless `ftw` = 0.

## Structure
- Shared package `sine_pkg` holds:
  - the default widths;
  - a function `quarter_sine(k, ADDR_W, DATA_W)` used to build the table;
  - the constant `MIDSCALE(DATA_W)`.
- Sub-module `quarter_sine_rom`, parameters ADDR_W and DATA_W:
  - synchronous read with enable;
  - table initialised via the package function in a generate loop (no external hex file);
  - one-cycle latency.
- The accumulator, phase mapping and scaler stay in the top level.

## Test plan
All scenarios use the defaults: PHASE_W=16, ADDR_W=6, DATA_W=12, AMP_W=8.
1. **Reset values:** hold `rst_n`=0 while toggling `en` → `d_out`=2048, `d_valid`=0, `wrap`=0 throughout.
2. **Full-period sweep:** `ftw`=0x0100, `amp`=255, `phase_off`=0, `en` every cycle.
   - → 256 samples per period.
   - → `wrap` asserted on exactly every 256th `d_valid`.
   - → the samples satisfy odd symmetry about 2048.
   - → first `d_valid` is exactly 3 cycles after the first `en`.
   - → the peak sample equals 2048 + ((2047·255)>>8).
3. **Zero amplitude:** `amp`=0 with any `ftw` → every `d_out`=2048.
4. **Phase offset and clear:** `ftw`=0x0400, `phase_off`=0x4000, `amp`=255; then pulse `sync_clr` together with `en`.
   - → that sample is the quarter-period maximum (entry 63, positive half).
   - → `wrap`=0 on that sample.
   - → the samples already in flight are unaffected.
5. **Reset mid-stream:** drop `rst_n` one cycle after 2 `en` pulses; release it.
   - → no `d_valid` is seen for those samples.
   - → the next `en` reproduces the post-reset first sample of scenario 2.
6. **Parameter sweep:** rerun scenario 2 with ADDR_W=4, DATA_W=8, comparing against a real-valued reference model → |error| ≤ 1 LSB.
